// File: rtl/cpu_types.sv
// Shared types for the OTTER out-of-order integer functional unit.
package cpu_types;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SLL  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SRL  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_AND  = 4'd7,
        ALU_SUB  = 4'd8,
        ALU_COPY = 4'd9,
        ALU_MUL  = 4'd10,
        ALU_SRA  = 4'd13
    } alu_fun_t;

    localparam int TAG_W_DEF = 4;
    typedef logic [TAG_W_DEF-1:0] RS_tag_type;
    localparam RS_tag_type TAG_INVALID = '1;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } fu_state_t;

endpackage

// File: rtl/fu_result_fifo.sv
// Result buffer between the functional unit and the CDB; a pop while full
// frees the slot for a same-cycle push.
module fu_result_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: empty masks the head at the top level.
    always_ff @(posedge clk) begin
        if (do_push && rst_n && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/otter_alu_fu.sv
// Integer functional unit: single-cycle ALU ops plus a multi-cycle multiply,
// results queued in order for CDB broadcast under request/grant.
//   state | meaning
//   IDLE  | accepting ops; non-mul results pushed on the accept edge
//   MUL   | multiply in flight; counter runs down to 1, then product is pushed
module otter_alu_fu
    import cpu_types::*;
#(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 4,
    parameter int MUL_LAT   = 3,
    parameter int OUT_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [3:0]       in_fun,
    input  logic [TAG_W-1:0] in_tag,
    output logic             cdb_req,
    input  logic             cdb_grant,
    output logic [XLEN-1:0]  cdb_val,
    output logic [TAG_W-1:0] cdb_tag,
    output logic             busy
);
    localparam int SH_W  = $clog2(XLEN);
    localparam int CNT_W = $clog2(OUT_DEPTH) + 1;
    localparam int MC_W  = $clog2(MUL_LAT) + 1;

    fu_state_t          state;
    logic [MC_W-1:0]    mul_cnt;
    logic [XLEN-1:0]    mul_a;
    logic [XLEN-1:0]    mul_b;
    logic [TAG_W-1:0]   mul_tag;
    logic [XLEN-1:0]    mul_prod;
    logic [XLEN-1:0]    alu_res;
    logic [SH_W-1:0]    shamt;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic [CNT_W-1:0]        fifo_count;
    logic [XLEN+TAG_W-1:0]   push_data;
    logic [XLEN+TAG_W-1:0]   head_data;

    logic accept;
    logic accept_mul;
    logic mul_done;

    assign shamt = in_b[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        case (in_fun)
            ALU_ADD:  alu_res = in_a + in_b;
            ALU_SUB:  alu_res = in_a - in_b;
            ALU_OR:   alu_res = in_a | in_b;
            ALU_AND:  alu_res = in_a & in_b;
            ALU_XOR:  alu_res = in_a ^ in_b;
            ALU_SRL:  alu_res = in_a >> shamt;
            ALU_SLL:  alu_res = in_a << shamt;
            ALU_SRA:  alu_res = XLEN'($signed(in_a) >>> shamt);
            ALU_SLT:  alu_res = XLEN'($signed(in_a) < $signed(in_b));
            ALU_SLTU: alu_res = XLEN'(in_a < in_b);
            ALU_COPY: alu_res = in_a;
            default:  alu_res = '0;
        endcase
    end

    assign mul_prod = mul_a * mul_b;

    // A same-cycle grant frees a slot; the mul also relies on this check to
    // reserve its FIFO entry, since nothing else pushes while it runs.
    assign fifo_pop   = cdb_grant && !fifo_empty;
    assign in_ready   = RST_N && !flush && (state == IDLE) && (!fifo_full || fifo_pop);
    assign accept     = in_valid && in_ready;
    assign accept_mul = accept && (in_fun == ALU_MUL);
    assign mul_done   = (state == MUL) && (mul_cnt == MC_W'(1));
    assign fifo_push  = mul_done || (accept && !accept_mul);
    assign push_data  = mul_done ? {mul_tag, mul_prod} : {in_tag, alu_res};

    always_ff @(posedge CLK) begin
        if (!RST_N || flush) begin
            state   <= IDLE;
            mul_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_mul) begin
                        state   <= MUL;
                        mul_cnt <= MC_W'(MUL_LAT - 1);
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        state   <= IDLE;
                        mul_cnt <= '0;
                    end else begin
                        mul_cnt <= mul_cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mul_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (accept_mul) begin
            mul_a   <= in_a;
            mul_b   <= in_b;
            mul_tag <= in_tag;
        end
    end

    fu_result_fifo #(
        .WIDTH (XLEN + TAG_W),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .flush (flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (push_data),
        .rdata (head_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign cdb_req = !fifo_empty;
    assign cdb_val = fifo_empty ? '0 : head_data[XLEN-1:0];
    assign cdb_tag = fifo_empty ? {TAG_W{1'b1}} : head_data[XLEN+TAG_W-1:XLEN];
    assign busy    = (state == MUL) || (fifo_count != '0);

endmodule

// File: tb/tb_otter_alu_fu.sv
// Scoreboard bench for otter_alu_fu: accepted ops push a reference result,
// a negedge monitor pops and compares each granted CDB broadcast.
module tb_otter_alu_fu;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [3:0]  in_fun = '0;
    logic [3:0]  in_tag = '0;
    logic        cdb_req;
    logic        cdb_grant = 1'b0;
    logic [31:0] cdb_val;
    logic [3:0]  cdb_tag;
    logic        busy;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    bit   rand_grant = 1'b0;

    otter_alu_fu #(
        .XLEN(32), .TAG_W(4), .MUL_LAT(3), .OUT_DEPTH(4)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_fun(in_fun), .in_tag(in_tag),
        .cdb_req(cdb_req), .cdb_grant(cdb_grant),
        .cdb_val(cdb_val), .cdb_tag(cdb_tag), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Reference behaviour written directly from the op table.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] f);
        int unsigned sh;
        logic [63:0] p;
        logic [31:0] fill;
        sh = b % 32;
        case (f)
            4'd0:  return a + b;
            4'd8:  return a - b;
            4'd6:  return a | b;
            4'd7:  return a & b;
            4'd4:  return a ^ b;
            4'd1:  return a << sh;
            4'd5:  return a >> sh;
            4'd13: begin
                fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
                return (a >> sh) | fill;
            end
            4'd2:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd3:  return (a < b) ? 32'd1 : 32'd0;
            4'd9:  return a;
            4'd10: begin
                p = {32'h0, a} * {32'h0, b};
                return p[31:0];
            end
            default: return 32'h0;
        endcase
    endfunction

    // Monitor: pops on granted broadcasts, models flush/reset, records accepts.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST_N) begin
            exp_q.delete();
        end else begin
            if (cdb_req && cdb_grant && !flush) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_result", {28'h0, cdb_tag}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_tag", {28'h0, cdb_tag}, {28'h0, e.tag});
                    check("sb_val", cdb_val, e.val);
                end
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) begin
                e.tag = in_tag;
                e.val = ref_alu(in_a, in_b, in_fun);
                exp_q.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        if (rand_grant) cdb_grant = 1'($urandom % 2);
    endtask

    // Called just after a posedge; returns just after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] f, input logic [3:0] t);
        int n = 0;
        in_valid = 1'b1;
        in_a = a; in_b = b; in_fun = f; in_tag = t;
        @(negedge CLK);
        while (!in_ready && n < 100) begin
            tick();
            @(negedge CLK);
            n++;
        end
        if (!in_ready) check("issue_timeout", {31'h0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic issue_expect(input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] f, input logic [3:0] t,
                                input logic [31:0] exp, input string name);
        issue(a, b, f, t);
        @(negedge CLK);
        check({name, "_req"}, {31'h0, cdb_req}, 32'd1);
        check({name, "_val"}, cdb_val, exp);
        check({name, "_tag"}, {28'h0, cdb_tag}, {28'h0, t});
        tick();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_in_ready"}, {31'h0, in_ready}, 32'd0);
        check({name, "_cdb_req"}, {31'h0, cdb_req}, 32'd0);
        check({name, "_cdb_val"}, cdb_val, 32'd0);
        check({name, "_cdb_tag"}, {28'h0, cdb_tag}, 32'hF);
        check({name, "_busy"}, {31'h0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic [3:0]  f;

        // Reset
        tick(); tick();
        @(negedge CLK);
        check_reset_outputs("reset");
        tick();
        RST_N = 1'b1;

        // Single sub, latency 1, then grant
        issue_expect(32'd5, 32'd3, 4'd8, 4'd7, 32'd2, "sub");
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
        @(negedge CLK);
        check("sub_after_grant_req", {31'h0, cdb_req}, 32'd0);
        check("sub_after_grant_tag", {28'h0, cdb_tag}, 32'hF);
        check("sub_after_grant_val", cdb_val, 32'd0);
        tick();

        // Multiply latency
        issue(32'd7, 32'd6, 4'd10, 4'd3);
        @(negedge CLK);
        check("mul_c1_ready", {31'h0, in_ready}, 32'd0);
        check("mul_c1_req", {31'h0, cdb_req}, 32'd0);
        check("mul_c1_busy", {31'h0, busy}, 32'd1);
        tick();
        @(negedge CLK);
        check("mul_c2_ready", {31'h0, in_ready}, 32'd0);
        check("mul_c2_req", {31'h0, cdb_req}, 32'd0);
        tick();
        @(negedge CLK);
        check("mul_c3_req", {31'h0, cdb_req}, 32'd1);
        check("mul_c3_val", cdb_val, 32'd42);
        check("mul_c3_ready", {31'h0, in_ready}, 32'd1);
        tick();
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;

        // Backpressure with four adds, fifth held until a grant
        for (int i = 1; i <= 4; i++) issue(32'(i * 10), 32'(i), 4'd0, 4'(i));
        in_valid = 1'b1; in_a = 32'd50; in_b = 32'd5; in_fun = 4'd0; in_tag = 4'd5;
        @(negedge CLK);
        check("bp_full_ready", {31'h0, in_ready}, 32'd0);
        tick();
        @(negedge CLK);
        check("bp_held_ready", {31'h0, in_ready}, 32'd0);
        tick();
        cdb_grant = 1'b1;
        @(negedge CLK);
        check("bp_grant_ready", {31'h0, in_ready}, 32'd1);
        check("bp_head_tag", {28'h0, cdb_tag}, 32'd1);
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        cdb_grant = 1'b0;
        @(negedge CLK);
        check("bp_drained", exp_q.size(), 32'd0);
        tick();

        // Shift/compare edges
        cdb_grant = 1'b1;
        issue_expect(32'h8000_0000, 32'd33, 4'd13, 4'd2, 32'hC000_0000, "sra");
        issue_expect(32'hFFFF_FFFF, 32'd1, 4'd2, 4'd4, 32'd1, "slt");
        issue_expect(32'hFFFF_FFFF, 32'd1, 4'd3, 4'd6, 32'd0, "sltu");
        issue_expect(32'h1234_5678, 32'd9, 4'd15, 4'd8, 32'd0, "undef");
        cdb_grant = 1'b0;

        // Flush with three buffered results and a mul in flight
        for (int i = 0; i < 3; i++) issue(32'(i), 32'd1, 4'd0, 4'(i + 10));
        issue(32'd9, 32'd9, 4'd10, 4'd13);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge CLK);
        check("flush_req", {31'h0, cdb_req}, 32'd0);
        check("flush_busy", {31'h0, busy}, 32'd0);
        check("flush_ready", {31'h0, in_ready}, 32'd1);
        tick();
        cdb_grant = 1'b1;
        repeat (5) begin
            @(negedge CLK);
            check("flush_no_mul_result", {31'h0, cdb_req}, 32'd0);
            tick();
        end
        cdb_grant = 1'b0;

        // Reset during MUL with two buffered results
        issue(32'd1, 32'd1, 4'd0, 4'd1);
        issue(32'd2, 32'd2, 4'd0, 4'd2);
        issue(32'd3, 32'd5, 4'd10, 4'd3);
        RST_N = 1'b0;
        tick();
        @(negedge CLK);
        check_reset_outputs("mid_reset");
        tick();
        RST_N = 1'b1;
        cdb_grant = 1'b1;
        issue_expect(32'd1, 32'd2, 4'd0, 4'd9, 32'd3, "post_reset_add");
        cdb_grant = 1'b0;

        // Randomized traffic under random grants
        rand_grant = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom % 4 == 0) tick();
            f = 4'($urandom % 16);
            a = ($urandom % 3 == 0) ? 32'($urandom % 64) : 32'($urandom);
            b = ($urandom % 3 == 0) ? 32'($urandom % 64) : 32'($urandom);
            issue(a, b, f, 4'($urandom % 15));
        end
        rand_grant = 1'b0;
        cdb_grant = 1'b1;
        repeat (20) tick();
        cdb_grant = 1'b0;
        @(negedge CLK);
        check("random_drained", exp_q.size(), 32'd0);
        check("random_idle_busy", {31'h0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
